bin_to_disp_codes: RTL and testbench
====================================

BIN_TO_DISP_CODES -- requirements
Module: bin_to_disp_codes

Interface
REQ-001 Parameter BLANK_LZ, default 1, meaning 1 = blank leading zeros, 0 = show all four digits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to convert value; sampled only in IDLE.
REQ-005 value  input  14  unsigned binary, legal range 0..9999.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when new codes are valid.
REQ-008 overflow  output  1  high when the last converted value exceeded 9999.
REQ-009 disp0, disp1, disp2, disp3  output  5 each  display codes; disp0 = ones digit, disp3 = thousands digit; these feed the 4-digit sweep driver directly.

Function
REQ-010 Code format SHALL be: bit4=0 means digit bits[3:0] (0..9); bit4=1 with bits[3:0]=0 means BLANK; bit4=1 with bits[3:0]=1 means DASH.
REQ-011 The FSM SHALL have states IDLE, SHIFT, LOAD_OUT; reset enters IDLE.
REQ-012 In IDLE, start=1 SHALL capture value into a 14-bit shift register, clear a 16-bit BCD accumulator and the iteration counter, and go to SHIFT.
REQ-013 Each SHIFT cycle SHALL add 3 to every BCD nibble that is >=5, then shift {BCD, binary} left by one bit.
REQ-014 SHIFT SHALL last exactly 14 cycles, counted by a 4-bit counter, then go to LOAD_OUT.
REQ-015 LOAD_OUT SHALL register disp0..disp3 and overflow, pulse done for exactly that one cycle, and return to IDLE.
REQ-016 Latency SHALL be 16 cycles: with start sampled at edge N, done is high during the cycle after edge N+15.
REQ-017 busy SHALL be high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-018 disp0..disp3 SHALL hold their previous values during a conversion and change only in the LOAD_OUT cycle.
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 A start in the same cycle that done is high SHALL be ignored; a new start is accepted from the next IDLE cycle onward.
REQ-021 value is sampled only on the start cycle; later changes SHALL not affect the conversion.
REQ-022 If value > 9999, all four outputs SHALL be DASH and overflow=1; the conversion still takes the full latency.
REQ-023 When BLANK_LZ=1, every zero digit above the most significant nonzero digit SHALL be BLANK.
REQ-024 disp0 SHALL never be blanked, so value 0 displays as a single "0".
REQ-025 overflow SHALL clear on the next non-overflow conversion.

Reset
REQ-026 While rst=1 the block SHALL go to IDLE, drive busy=0, done=0 and overflow=0, and set disp0..disp3 to BLANK.
REQ-027 rst asserted mid-conversion SHALL abort it, with no done pulse and outputs reset as in REQ-026.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package disp7seg_pkg SHALL hold:
  - the code constants: digit encoding, CODE_BLANK = 5'b10000, CODE_DASH = 5'b10001;
  - the FSM state enum;
  - the constant NDIGITS = 4.
REQ-030 The add-3 correction SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated once per nibble.

Verification
REQ-031 start with value=1234 -> 16 cycles later done=1, disp3..disp0 = 01,02,03,04 (hex), overflow=0.
REQ-032 value=7 with BLANK_LZ=1 -> disp3..disp1 = 10, disp0 = 07; the same value with BLANK_LZ=0 -> 00,00,00,07.
REQ-033 value=0 -> disp3..disp1 = 10, disp0 = 00; value=9999 -> 09,09,09,09.
REQ-034 value=12000 -> all outputs 11, overflow=1; then value=5 -> overflow=0 and disp0 = 05.
REQ-035 start at 1234, then start=1 with value=42 at cycle 5 -> only one done pulse, result 1234; a start on the done cycle is also ignored.
REQ-036 rst=1 at cycle 8 of a conversion -> no done pulse, busy=0, all outputs 10; a fresh start then converts normally.

Source files
------------

// File: rtl/disp7seg_pkg.sv
// Shared constants and types for the binary-to-display-code converter.
package disp7seg_pkg;

  // Display code: bit4=0 -> decimal digit in [3:0]; bit4=1 -> special symbol
  localparam logic [4:0] CODE_BLANK = 5'b10000;
  localparam logic [4:0] CODE_DASH  = 5'b10001;

  localparam int unsigned NDIGITS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    LOAD_OUT = 2'd2
  } state_t;

  // Encode a BCD nibble as a visible digit code
  function automatic logic [4:0] digit_code(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-shift correction so the nibble carries correctly into the next digit
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_disp_codes.sv
// Sequential binary-to-BCD converter (double dabble) producing four display codes.
module bin_to_disp_codes
  import disp7seg_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [4:0]  disp0,
  output logic [4:0]  disp1,
  output logic [4:0]  disp2,
  output logic [4:0]  disp3
);

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt;
  logic        ov_pend;

  logic [4:0]  nxt0, nxt1, nxt2, nxt3;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd[4*i +: 4]),
      .dout (bcd_adj[4*i +: 4])
    );
  end

  // Busy covers the shift and load cycles plus the done cycle itself
  always_comb begin
    busy = (state != IDLE) || done;
  end

  // Final display codes from the accumulated BCD digits
  always_comb begin
    nxt0 = digit_code(bcd[3:0]);
    nxt1 = digit_code(bcd[7:4]);
    nxt2 = digit_code(bcd[11:8]);
    nxt3 = digit_code(bcd[15:12]);
    if (ov_pend) begin
      nxt0 = CODE_DASH;
      nxt1 = CODE_DASH;
      nxt2 = CODE_DASH;
      nxt3 = CODE_DASH;
    end else if (BLANK_LZ) begin
      if (bcd[15:12] == 4'd0) nxt3 = CODE_BLANK;
      if (bcd[15:8] == 8'd0)  nxt2 = CODE_BLANK;
      if (bcd[15:4] == 12'd0) nxt1 = CODE_BLANK;
    end
  end

  // Control FSM, shift datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ov_pend  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      disp0    <= CODE_BLANK;
      disp1    <= CODE_BLANK;
      disp2    <= CODE_BLANK;
      disp3    <= CODE_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done high means the previous result is still being presented
          if (start && !done) begin
            bin     <= value;
            bcd     <= '0;
            cnt     <= '0;
            ov_pend <= (value > 14'd9999);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj[14:0], bin[13]};
          bin     <= {bin[12:0], 1'b0};
          // a carry out of the top digit can only come from an out-of-range value
          ov_pend <= ov_pend | bcd_adj[15];
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd13) state <= LOAD_OUT;
        end
        LOAD_OUT: begin
          disp0    <= nxt0;
          disp1    <= nxt1;
          disp2    <= nxt2;
          disp3    <= nxt3;
          overflow <= ov_pend;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_disp_codes.sv
// Directed self-checking bench for bin_to_disp_codes (both blanking modes).
module tb_bin_to_disp_codes;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;

  logic        busy_a, done_a, ov_a;
  logic [4:0]  a0, a1, a2, a3;
  logic        busy_b, done_b, ov_b;
  logic [4:0]  b0, b1, b2, b3;

  logic [19:0] cat_a, cat_b;
  assign cat_a = {a3, a2, a1, a0};
  assign cat_b = {b3, b2, b1, b0};

  int checks = 0;
  int errors = 0;

  localparam logic [19:0] ALL_BLANK = {5'h10, 5'h10, 5'h10, 5'h10};
  localparam logic [19:0] ALL_DASH  = {5'h11, 5'h11, 5'h11, 5'h11};

  always #5 clk = ~clk;

  bin_to_disp_codes dut_a (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .overflow(ov_a),
    .disp0(a0), .disp1(a1), .disp2(a2), .disp3(a3)
  );

  bin_to_disp_codes #(.BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .overflow(ov_b),
    .disp0(b0), .disp1(b1), .disp2(b2), .disp3(b3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One conversion: checks latency, busy, held outputs, single done pulse
  task automatic run(input string tag, input logic [13:0] v);
    int unsigned n;
    logic [19:0] prev;
    prev  = cat_a;
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = ~v;
    chk({tag, "_busy"}, 20'(busy_a), 20'd1);
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 8) chk({tag, "_hold"}, cat_a, prev);
    end
    chk({tag, "_latency"}, 20'(n), 20'd15);
    chk({tag, "_busy_done"}, 20'(busy_a), 20'd1);
    tick();
    chk({tag, "_done_pulse"}, 20'(done_a), 20'd0);
    chk({tag, "_busy_end"}, 20'(busy_a), 20'd0);
  endtask

  initial begin
    int unsigned dones;
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) tick();
    chk("rst_busy", 20'(busy_a), 20'd0);
    chk("rst_done", 20'(done_a), 20'd0);
    chk("rst_ov", 20'(ov_a), 20'd0);
    chk("rst_disp", cat_a, ALL_BLANK);
    rst = 1'b0;
    tick();

    run("v1234", 14'd1234);
    chk("v1234_disp", cat_a, {5'h01, 5'h02, 5'h03, 5'h04});
    chk("v1234_ov", 20'(ov_a), 20'd0);

    run("v7", 14'd7);
    chk("v7_blank", cat_a, {5'h10, 5'h10, 5'h10, 5'h07});
    chk("v7_noblank", cat_b, {5'h00, 5'h00, 5'h00, 5'h07});

    run("v0", 14'd0);
    chk("v0_blank", cat_a, {5'h10, 5'h10, 5'h10, 5'h00});
    chk("v0_noblank", cat_b, 20'd0);

    run("v9999", 14'd9999);
    chk("v9999_disp", cat_a, {5'h09, 5'h09, 5'h09, 5'h09});
    chk("v9999_ov", 20'(ov_a), 20'd0);

    run("v1050", 14'd1050);
    chk("v1050_disp", cat_a, {5'h01, 5'h00, 5'h05, 5'h00});

    run("v12000", 14'd12000);
    chk("v12000_disp", cat_a, ALL_DASH);
    chk("v12000_disp_b", cat_b, ALL_DASH);
    chk("v12000_ov", 20'(ov_a), 20'd1);

    run("v5", 14'd5);
    chk("v5_ov", 20'(ov_a), 20'd0);
    chk("v5_disp", cat_a, {5'h10, 5'h10, 5'h10, 5'h05});

    // Starts while busy and on the done cycle must both be dropped
    start = 1'b1;
    value = 14'd1234;
    tick();
    start = 1'b0;
    value = 14'd42;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
      if (done_a === 1'b1) begin
        dones++;
        start = 1'b1;
        value = 14'd42;
        tick();
        start = 1'b0;
      end
    end
    chk("ignore_dones", 20'(dones), 20'd1);
    chk("ignore_result", cat_a, {5'h01, 5'h02, 5'h03, 5'h04});
    chk("ignore_idle", 20'(busy_a), 20'd0);

    // Reset in the middle of a conversion aborts it
    start = 1'b1;
    value = 14'd5678;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 20'(busy_a), 20'd0);
    chk("abort_done", 20'(done_a), 20'd0);
    chk("abort_disp", cat_a, ALL_BLANK);
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_over_start", 20'(busy_a), 20'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a === 1'b1) dones++;
    end
    chk("abort_no_done", 20'(dones), 20'd0);
    chk("abort_disp_kept", cat_a, ALL_BLANK);

    run("v4321", 14'd4321);
    chk("v4321_disp", cat_a, {5'h04, 5'h03, 5'h02, 5'h01});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
